// File: rtl/feed_pkg.sv
// Shared constants and state encodings for the order-feed message writer.
// The error counters of feed_buffer_writer exist only when FEED_ERR_CNT_EN is defined.
package feed_pkg;

  localparam int MSG_BYTES_DEF = 41;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL    = 2'd2
  } slot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_RECV    = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_e;

endpackage

// File: rtl/feed_msg_slot.sv
// One message slot: MSG_BYTES byte registers, byte write at an index and a whole-slot clear.
// Byte 0 is presented in the most significant byte of the flattened output.
module feed_msg_slot
  import feed_pkg::*;
#(
  parameter int MSG_BYTES = MSG_BYTES_DEF,
  parameter int IDX_W     = $clog2(MSG_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic                   clear,
  input  logic [IDX_W-1:0]       idx,
  input  logic [7:0]             data,
  output logic [8*MSG_BYTES-1:0] bytes
);

  logic [7:0] mem [MSG_BYTES];

  // NOTE: the byte array is reset on purpose; the presented buffer must read as zero in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_BYTES; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < MSG_BYTES; i++) mem[i] <= '0;
    end else if (we) begin
      // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
      mem[idx] <= data;
    end
  end

  for (genvar i = 0; i < MSG_BYTES; i++) begin : g_flat
    assign bytes[8*(MSG_BYTES-i)-1 -: 8] = mem[i];
  end

endmodule

// File: rtl/feed_buffer_writer.sv
// Assembles framed stream bytes into two ping-pong message slots and presents the oldest full one.
// Define FEED_ERR_CNT_EN to add the saturating runt_cnt / giant_cnt drop counters.
module feed_buffer_writer
  import feed_pkg::*;
#(
  parameter int MSG_BYTES = MSG_BYTES_DEF,
  parameter int ERR_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  output logic                   in_ready,
  output logic [8*MSG_BYTES-1:0] ff_buffer,
  output logic                   buffer_not_empty,
  input  logic                   system_free
`ifdef FEED_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0]       runt_cnt,
  output logic [ERR_W-1:0]       giant_cnt
`endif
);

  localparam int CW = $clog2(MSG_BYTES + 1);

  rx_state_e   state, state_nx;
  slot_state_e slot_st [2];
  slot_state_e slot_nx [2];
  logic        wr_slot, wr_slot_nx, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count, count_nx, widx;
  logic        xfer, consume, any_empty, low_empty, tgt, we, clr;
  logic [8*MSG_BYTES-1:0] slot_data [2];
`ifdef FEED_ERR_CNT_EN
  logic [1:0]  runt_inc;
  logic        giant_inc;
`endif

  assign any_empty        = (slot_st[0] == SLOT_EMPTY) || (slot_st[1] == SLOT_EMPTY);
  assign low_empty        = (slot_st[0] != SLOT_EMPTY);
  assign in_ready         = !reset && ((state != RX_IDLE) || any_empty);
  assign xfer             = in_valid && in_ready;
  assign buffer_not_empty = (slot_st[rd_ptr] == SLOT_FULL);
  assign consume          = buffer_not_empty && system_free;
  assign ff_buffer        = slot_data[rd_ptr];

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    state_nx   = state;
    slot_nx    = slot_st;
    wr_slot_nx = wr_slot;
    count_nx   = count;
    tgt        = wr_slot;
    we         = 1'b0;
    clr        = 1'b0;
    widx       = count;
`ifdef FEED_ERR_CNT_EN
    runt_inc   = 2'd0;
    giant_inc  = 1'b0;
`endif
    if (consume) slot_nx[rd_ptr] = SLOT_EMPTY;

    if (xfer) begin
      if (in_sop) begin
        // A new sop while receiving abandons the current message and reuses its slot.
        if (state == RX_RECV) begin
`ifdef FEED_ERR_CNT_EN
          runt_inc = 2'd1;
`endif
        end else begin
          tgt = low_empty;
        end
        wr_slot_nx = tgt;
        we         = 1'b1;
        widx       = '0;
        if (in_eop && MSG_BYTES != 1) begin
          slot_nx[tgt] = SLOT_EMPTY;
          clr          = 1'b1;
          count_nx     = '0;
          state_nx     = RX_IDLE;
`ifdef FEED_ERR_CNT_EN
          runt_inc     = runt_inc + 2'd1;
`endif
        end else if (in_eop) begin
          slot_nx[tgt] = SLOT_FULL;
          count_nx     = '0;
          state_nx     = RX_IDLE;
        end else begin
          slot_nx[tgt] = SLOT_FILLING;
          count_nx     = CW'(1);
          state_nx     = RX_RECV;
        end
      end else if (state == RX_RECV) begin
        if (count == CW'(MSG_BYTES)) begin
          slot_nx[tgt] = SLOT_EMPTY;
          clr          = 1'b1;
          count_nx     = '0;
          state_nx     = in_eop ? RX_IDLE : RX_DISCARD;
`ifdef FEED_ERR_CNT_EN
          giant_inc    = 1'b1;
`endif
        end else begin
          we = 1'b1;
          if (in_eop) begin
            count_nx = '0;
            state_nx = RX_IDLE;
            if (count == CW'(MSG_BYTES - 1)) begin
              slot_nx[tgt] = SLOT_FULL;
            end else begin
              slot_nx[tgt] = SLOT_EMPTY;
              clr          = 1'b1;
`ifdef FEED_ERR_CNT_EN
              runt_inc     = 2'd1;
`endif
            end
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end else if (state == RX_DISCARD && in_eop) begin
        state_nx = RX_IDLE;
      end
    end

    // Read pointer tracks the oldest full slot; it only moves when its slot stops being full.
    rd_ptr_nx = rd_ptr;
    if (slot_nx[rd_ptr] != SLOT_FULL && slot_nx[~rd_ptr] == SLOT_FULL) rd_ptr_nx = ~rd_ptr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      slot_st[0] <= SLOT_EMPTY;
      slot_st[1] <= SLOT_EMPTY;
      wr_slot    <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_nx;
      slot_st    <= slot_nx;
      wr_slot    <= wr_slot_nx;
      rd_ptr     <= rd_ptr_nx;
      count      <= count_nx;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_slot
    feed_msg_slot #(.MSG_BYTES(MSG_BYTES), .IDX_W(CW)) u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (we && (tgt == 1'(k))),
      .clear (clr && (tgt == 1'(k))),
      .idx   (widx),
      .data  (in_data),
      .bytes (slot_data[k])
    );
  end

`ifdef FEED_ERR_CNT_EN
  logic [ERR_W:0] runt_sum, giant_sum;
  assign runt_sum  = {1'b0, runt_cnt} + (ERR_W+1)'(runt_inc);
  assign giant_sum = {1'b0, giant_cnt} + (ERR_W+1)'(giant_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runt_cnt  <= '0;
      giant_cnt <= '0;
    end else begin
      runt_cnt  <= runt_sum[ERR_W]  ? '1 : runt_sum[ERR_W-1:0];
      giant_cnt <= giant_sum[ERR_W] ? '1 : giant_sum[ERR_W-1:0];
    end
  end
`endif

endmodule
